branch_resolve_bht: RTL

Branch resolution and prediction unit for the 4-stage pipeline. It takes the flags the ALU produces for a conditional branch (zero flag, compare flag) and uses them to resolve the branch in EX. A predict-taken mismatch triggers a one-cycle flush and a redirect PC. The block also owns a table of 2-bit saturating counters, indexed by PC, that gives fetch its taken/not-taken prediction, and it keeps branch and mispredict statistics counters.

---
 rtl/branch_resolve_bht.sv | 101 ++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
// Branch resolution and 2-bit BHT prediction unit.
// Resolves conditional branches in EX from the ALU flags and raises a one-cycle
// flush with a redirect PC on a mispredict. Also holds the bimodal predictor
// that fetch uses, plus saturating branch and mispredict statistics.
module branch_resolve_bht #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] if_pc,
    input  logic             if_is_branch,
    input  logic [WIDTH-1:0] if_target,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_next_pc,
    input  logic             ex_valid,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_z_flag,
    input  logic             ex_o_flag,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    output logic             flush,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CW-1:0]    branch_cnt,
    output logic [CW-1:0]    mispred_cnt
);

    localparam int IDX = $clog2(ENTRIES);

    logic [1:0]     bht [ENTRIES];
    logic [IDX-1:0] if_idx;
    logic [IDX-1:0] ex_idx;
    logic           act;
    logic           legal;
    logic           upd;
    logic           mp;

    // Word-aligned PCs: drop the two byte-offset bits before indexing.
    assign if_idx = if_pc[IDX+1:2];
    assign ex_idx = ex_pc[IDX+1:2];

    // Fetch-side prediction sees the table before any same-cycle update.
    assign pred_taken   = if_is_branch & bht[if_idx][1];
    assign pred_next_pc = pred_taken ? if_target : if_pc + WIDTH'(4);

    // Decode actual branch outcome from funct3 and ALU flags.
    always_comb begin
        act   = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:  act = ex_z_flag;
            3'b001:  act = ~ex_z_flag;
            3'b100:  act = ex_o_flag;
            3'b101:  act = ~ex_o_flag;
            3'b110:  act = ex_o_flag;
            3'b111:  act = ~ex_o_flag;
            default: legal = 1'b0;
        endcase
    end

    // An EX branch seen while flushing is wrong-path and must not train anything.
    assign upd = ex_valid & ~flush & legal;
    assign mp  = upd & (act != ex_pred_taken);

    // Train the 2-bit saturating counter of the resolving branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd) begin
            if (act && bht[ex_idx] != 2'b11)
                bht[ex_idx] <= bht[ex_idx] + 2'd1;
            else if (!act && bht[ex_idx] != 2'b00)
                bht[ex_idx] <= bht[ex_idx] - 2'd1;
        end
    end

    // One-cycle flush pulse; redirect_pc keeps its value between mispredicts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mp;
            if (mp) redirect_pc <= act ? ex_target : ex_pc + WIDTH'(4);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd && branch_cnt != {CW{1'b1}})  branch_cnt  <= branch_cnt + CW'(1);
            if (mp && mispred_cnt != {CW{1'b1}})  mispred_cnt <= mispred_cnt + CW'(1);
        end
    end

endmodule
